// File: rtl/ssit_pkg.sv
// Shared types and widths for the SSIT update/maintenance controller.
package ssit_pkg;

  localparam int SSIT_IDX_W = 12;
  localparam int SSID_W     = 7;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    RESP   = 3'd2,
    WRITE  = 3'd3,
    CLEAR  = 3'd4
  } ssit_ctrl_state_e;

  // One memory-order-violation report: the offending load/store pair.
  typedef struct packed {
    logic [SSIT_IDX_W-1:0] ld_idx;
    logic [SSIT_IDX_W-1:0] st_idx;
  } ssit_viol_req_t;

  // Merging two live store sets keeps the numerically smaller SSID.
  function automatic logic [SSID_W-1:0] ssid_min(input logic [SSID_W-1:0] a,
                                                 input logic [SSID_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ssit_req_fifo.sv
// Synchronous FIFO holding pending violation reports.
// A push is taken only when the queue was not full at the start of the
// cycle, even if a pop happens in the same cycle.
module ssit_req_fifo
  import ssit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_push,
  input  ssit_viol_req_t i_data,
  input  logic           i_pop,
  output ssit_viol_req_t o_data,
  output logic           o_full,
  output logic           o_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  ssit_viol_req_t r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; reset empties the queue immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ssit_ctrl.sv
// SSIT update and maintenance controller.
// Queues load/store violation reports, looks up both SSIDs, applies the
// store-set merge rule and writes the result back to both SSIT entries.
// Optional feature macro: SSIT_CYCLIC_CLEAR_EN enables the periodic flash
// clear of SSIT and LFST (period 2^CLR_PERIOD_LOG2 cycles).
//
// Handshake: a report is transferred on any clock edge where viol_vld_i and
// viol_rdy_o are both high; viol_rdy_o depends only on queue occupancy, and
// the source may change the payload freely when no transfer occurs.
module ssit_ctrl
  import ssit_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int CLR_PERIOD_LOG2 = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  viol_vld_i,
  output logic                  viol_rdy_o,
  input  logic [SSIT_IDX_W-1:0] viol_ld_idx_i,
  input  logic [SSIT_IDX_W-1:0] viol_st_idx_i,
  output logic [SSIT_IDX_W-1:0] ssit_ridx0_o,
  output logic [SSIT_IDX_W-1:0] ssit_ridx1_o,
  input  logic [SSID_W-1:0]     ssit_rssid0_i,
  input  logic [SSID_W-1:0]     ssit_rssid1_i,
  input  logic                  ssit_rvld0_i,
  input  logic                  ssit_rvld1_i,
  output logic [SSIT_IDX_W-1:0] ssit_widx0_o,
  output logic [SSIT_IDX_W-1:0] ssit_widx1_o,
  output logic [SSID_W-1:0]     ssit_wssid_o,
  output logic                  ssit_we_o,
  output logic                  ssit_clr_o,
  output logic                  lfst_flush_o,
  output logic                  busy_o,
  output logic [2:0]            dbg_state_o
);

  ssit_ctrl_state_e      r_state;
  ssit_ctrl_state_e      w_next_state;
  ssit_viol_req_t        r_req;
  ssit_viol_req_t        w_fifo_data;
  ssit_viol_req_t        w_push_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_clr_pending;
  logic [SSIT_IDX_W-1:0] r_widx0;
  logic [SSIT_IDX_W-1:0] r_widx1;
  logic [SSID_W-1:0]     r_wssid;
  logic                  r_skip;
  logic [SSID_W-1:0]     r_alloc;
  logic [SSID_W-1:0]     w_merge_ssid;
  logic                  w_merge_skip;
  logic                  w_alloc_use;

  assign w_push_data.ld_idx = viol_ld_idx_i;
  assign w_push_data.st_idx = viol_st_idx_i;

  ssit_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (viol_vld_i),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef SSIT_CYCLIC_CLEAR_EN
  logic [CLR_PERIOD_LOG2-1:0] r_period;
  logic                       r_clr_pending;

  // Free-running period counter; its wrap arms a pending clear that is
  // honoured only from IDLE, so an in-flight request always finishes first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_period      <= '0;
      r_clr_pending <= 1'b0;
    end else begin
      r_period <= r_period + 1'b1;
      if (r_period == '1) begin
        r_clr_pending <= 1'b1;
      end else if (r_state == CLEAR) begin
        r_clr_pending <= 1'b0;
      end
    end
  end

  assign w_clr_pending = r_clr_pending;
  assign ssit_clr_o    = (r_state == CLEAR);
  assign lfst_flush_o  = (r_state == CLEAR);
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = (CLR_PERIOD_LOG2 > 0);
  assign w_clr_pending = 1'b0;
  assign ssit_clr_o    = 1'b0;
  assign lfst_flush_o  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, queue pop and write strobe.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    ssit_we_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_clr_pending) begin
          w_next_state = CLEAR;
        end else if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = LOOKUP;
        end
      end
      LOOKUP:  w_next_state = RESP;
      RESP:    w_next_state = WRITE;
      WRITE: begin
        ssit_we_o    = !r_skip;
        w_next_state = IDLE;
      end
      CLEAR:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Store-set merge rule applied to the lookup response.
  always_comb begin
    w_merge_ssid = r_alloc;
    w_merge_skip = 1'b0;
    w_alloc_use  = 1'b0;
    case ({ssit_rvld0_i, ssit_rvld1_i})
      2'b00: begin
        w_merge_ssid = r_alloc;
        w_alloc_use  = 1'b1;
      end
      2'b10:   w_merge_ssid = ssit_rssid0_i;
      2'b01:   w_merge_ssid = ssit_rssid1_i;
      default: begin
        if (ssit_rssid0_i == ssit_rssid1_i) begin
          w_merge_ssid = ssit_rssid0_i;
          w_merge_skip = 1'b1;
        end else begin
          w_merge_ssid = ssid_min(ssit_rssid0_i, ssit_rssid1_i);
        end
      end
    endcase
  end

  // Request holding register (drives lookup indices) and write-port
  // registers; both hold their value until the next strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req   <= '0;
      r_widx0 <= '0;
      r_widx1 <= '0;
      r_wssid <= '0;
      r_skip  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_req <= w_fifo_data;
      end
      if (r_state == RESP) begin
        r_skip <= w_merge_skip;
        if (!w_merge_skip) begin
          r_widx0 <= r_req.ld_idx;
          r_widx1 <= r_req.st_idx;
          r_wssid <= w_merge_ssid;
        end
      end
    end
  end

  // SSID allocator: advances on each fresh allocation, wraps freely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alloc <= '0;
`ifdef SSIT_CYCLIC_CLEAR_EN
    end else if (r_state == CLEAR) begin
      r_alloc <= '0;
`endif
    end else if ((r_state == RESP) && w_alloc_use) begin
      r_alloc <= r_alloc + 1'b1;
    end
  end

  assign viol_rdy_o   = !w_full;
  assign busy_o       = (r_state != IDLE) || !w_empty;
  assign ssit_ridx0_o = r_req.ld_idx;
  assign ssit_ridx1_o = r_req.st_idx;
  assign ssit_widx0_o = r_widx0;
  assign ssit_widx1_o = r_widx1;
  assign ssit_wssid_o = r_wssid;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_ssit_ctrl.sv
// Testbench for ssit_ctrl: directed vector table, multi-cycle sequences
// (latency, backpressure, reset mid-request, cyclic clear) and randomized
// reports checked against a sequential store-set model.
module tb_ssit_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- main DUT ----------------
  logic        viol_vld_i = 1'b0;
  logic        viol_rdy_o;
  logic [11:0] viol_ld_idx_i = '0, viol_st_idx_i = '0;
  logic [11:0] ssit_ridx0_o, ssit_ridx1_o;
  logic [6:0]  ssit_rssid0_i = '0, ssit_rssid1_i = '0;
  logic        ssit_rvld0_i = 1'b0, ssit_rvld1_i = 1'b0;
  logic [11:0] ssit_widx0_o, ssit_widx1_o;
  logic [6:0]  ssit_wssid_o;
  logic        ssit_we_o, ssit_clr_o, lfst_flush_o, busy_o;
  logic [2:0]  dbg_state_o;

  ssit_ctrl #(.FIFO_DEPTH(4), .CLR_PERIOD_LOG2(20)) dut (
    .clock(clock), .reset(reset),
    .viol_vld_i(viol_vld_i), .viol_rdy_o(viol_rdy_o),
    .viol_ld_idx_i(viol_ld_idx_i), .viol_st_idx_i(viol_st_idx_i),
    .ssit_ridx0_o(ssit_ridx0_o), .ssit_ridx1_o(ssit_ridx1_o),
    .ssit_rssid0_i(ssit_rssid0_i), .ssit_rssid1_i(ssit_rssid1_i),
    .ssit_rvld0_i(ssit_rvld0_i), .ssit_rvld1_i(ssit_rvld1_i),
    .ssit_widx0_o(ssit_widx0_o), .ssit_widx1_o(ssit_widx1_o),
    .ssit_wssid_o(ssit_wssid_o), .ssit_we_o(ssit_we_o),
    .ssit_clr_o(ssit_clr_o), .lfst_flush_o(lfst_flush_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- short-period DUT for the cyclic clear ----------------
  logic        c_vld = 1'b0, c_rdy;
  logic [11:0] c_ld = 12'h001, c_st = 12'h002;
  logic [11:0] c_ridx0, c_ridx1, c_widx0, c_widx1;
  logic [6:0]  c_rssid = '0, c_wssid;
  logic        c_rvld = 1'b0;
  logic        c_we, c_clr, c_flush, c_busy;
  logic [2:0]  c_dbg;

  ssit_ctrl #(.FIFO_DEPTH(4), .CLR_PERIOD_LOG2(4)) dut_c (
    .clock(clock), .reset(reset),
    .viol_vld_i(c_vld), .viol_rdy_o(c_rdy),
    .viol_ld_idx_i(c_ld), .viol_st_idx_i(c_st),
    .ssit_ridx0_o(c_ridx0), .ssit_ridx1_o(c_ridx1),
    .ssit_rssid0_i(c_rssid), .ssit_rssid1_i(c_rssid),
    .ssit_rvld0_i(c_rvld), .ssit_rvld1_i(c_rvld),
    .ssit_widx0_o(c_widx0), .ssit_widx1_o(c_widx1),
    .ssit_wssid_o(c_wssid), .ssit_we_o(c_we),
    .ssit_clr_o(c_clr), .lfst_flush_o(c_flush),
    .busy_o(c_busy), .dbg_state_o(c_dbg)
  );

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- SSIT memory environment (1-cycle read) ----------------
  logic       env_vld [4096];
  logic [6:0] env_id  [4096];
  int         env_a0, env_a1;

  always @(posedge clock) begin
    env_a0 = ssit_ridx0_o;
    env_a1 = ssit_ridx1_o;
    if (ssit_we_o) begin
      env_vld[ssit_widx0_o] = 1'b1; env_id[ssit_widx0_o] = ssit_wssid_o;
      env_vld[ssit_widx1_o] = 1'b1; env_id[ssit_widx1_o] = ssit_wssid_o;
    end
    if (ssit_clr_o) begin
      for (int i = 0; i < 4096; i++) env_vld[i] = 1'b0;
    end
    #1;
    ssit_rssid0_i = env_id[env_a0];
    ssit_rvld0_i  = env_vld[env_a0];
    ssit_rssid1_i = env_id[env_a1];
    ssit_rvld1_i  = env_vld[env_a1];
  end

  // ---------------- reference model: reports processed in order ----------------
  logic        m_vld [4096];
  logic [6:0]  m_id  [4096];
  int          m_alloc;
  logic [30:0] exp_q [$];   // {widx0, widx1, wssid}
  int          wr_cyc [$];
  logic        mon_en = 1'b0;
  int          we_count = 0;
  int          clr_count = 0;
  logic [30:0] mon_got, mon_exp;

  task automatic model_sync();
    for (int i = 0; i < 4096; i++) begin
      m_vld[i] = env_vld[i];
      m_id[i]  = env_id[i];
    end
    m_alloc = 0;
    exp_q.delete();
    wr_cyc.delete();
  endtask

  task automatic model_accept(input logic [11:0] ld, input logic [11:0] st);
    int  s0, s1, s;
    bit  v0, v1, skip;
    v0 = m_vld[ld]; s0 = m_id[ld];
    v1 = m_vld[st]; s1 = m_id[st];
    skip = 0;
    if (!v0 && !v1) begin
      s = m_alloc;
      m_alloc = (m_alloc + 1) % 128;
    end else if (v0 && !v1) s = s0;
    else if (!v0 && v1)     s = s1;
    else if (s0 == s1)      begin s = s0; skip = 1; end
    else                    s = (s0 < s1) ? s0 : s1;
    if (!skip) begin
      m_vld[ld] = 1'b1; m_id[ld] = 7'(s);
      m_vld[st] = 1'b1; m_id[st] = 7'(s);
      exp_q.push_back({ld, st, 7'(s)});
    end
  endtask

  // Write-port scoreboard on the main DUT.
  always @(negedge clock) begin
    if (ssit_we_o) begin
      we_count++;
      if (mon_en) begin
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_got = {ssit_widx0_o, ssit_widx1_o, ssit_wssid_o};
          mon_exp = exp_q.pop_front();
          check("wr_data", mon_got, mon_exp);
          wr_cyc.push_back(cyc);
        end
      end
    end
    if (ssit_clr_o || lfst_flush_o) clr_count++;
  end

  // Cyclic-clear monitor on the short-period DUT.
  logic c_mon_en = 1'b0;
  int   c_exp_alloc = 0;
  int   c_clr_n = 0, c_we_n = 0, c_clr_tot = 0;
  logic c_prev_clr = 1'b0, c_prev_we = 1'b0;

  always @(negedge clock) begin
    if (c_clr || c_flush) c_clr_tot++;
    if (c_mon_en) begin
      if (c_clr) begin
        check("c_flush_with_clr", c_flush, 1);
        check("c_clr_single_cycle", c_prev_clr, 0);
        check("c_clr_after_idle", c_prev_we, 0);
        c_exp_alloc = 0;
        c_clr_n++;
      end
      if (c_we) begin
        check("c_wssid", c_wssid, 32'(c_exp_alloc));
        check("c_widx0", c_widx0, 12'h001);
        check("c_widx1", c_widx1, 12'h002);
        check("c_ridx0_hold", c_ridx0, 12'h001);
        c_exp_alloc = (c_exp_alloc + 1) % 128;
        c_we_n++;
      end
    end
    c_prev_clr = c_clr;
    c_prev_we  = c_we;
  end

  // ---------------- driver tasks ----------------
  task automatic push_one(input logic [11:0] ld, input logic [11:0] st);
    int guard;
    @(negedge clock);
    viol_vld_i = 1'b1; viol_ld_idx_i = ld; viol_st_idx_i = st;
    guard = 0;
    while (!viol_rdy_o && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check("push_rdy_timeout", viol_rdy_o, 1);
    if (mon_en) model_accept(ld, st);
    @(posedge clock);
    #1;
    viol_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy_o) && g < 3000) begin
      @(negedge clock);
      g++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", busy_o, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [11:0] ld, st;
    logic        v0;
    logic [6:0]  s0;
    logic        v1;
    logic [6:0]  s1;
    logic        we;
    logic [6:0]  ssid;
  } vec_t;
  vec_t vecs [8];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d;
    for (int i = 0; i < 4096; i++) begin
      env_vld[i] = 1'b0; env_id[i] = '0;
    end
    //           ld       st     v0  s0     v1  s1     we  ssid
    vecs[0] = '{12'h010, 12'h020, 0, 7'h00, 0, 7'h00, 1, 7'h00};
    vecs[1] = '{12'h030, 12'h040, 1, 7'h05, 0, 7'h00, 1, 7'h05};
    vecs[2] = '{12'h050, 12'h060, 0, 7'h00, 1, 7'h33, 1, 7'h33};
    vecs[3] = '{12'h070, 12'h080, 1, 7'h12, 1, 7'h07, 1, 7'h07};
    vecs[4] = '{12'h090, 12'h0A0, 1, 7'h09, 1, 7'h09, 0, 7'h00};
    vecs[5] = '{12'h0B0, 12'h0C0, 1, 7'h7F, 1, 7'h00, 1, 7'h00};
    vecs[6] = '{12'h0D0, 12'h0E0, 0, 7'h00, 0, 7'h00, 1, 7'h01};
    vecs[7] = '{12'h0F0, 12'h0F0, 0, 7'h00, 0, 7'h00, 1, 7'h02};

    // Reset values, sampled while reset is held.
    @(negedge clock);
    check("rst_rdy", viol_rdy_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_we", ssit_we_o, 0);
    check("rst_clr", ssit_clr_o, 0);
    check("rst_flush", lfst_flush_o, 0);
    check("rst_ridx0", ssit_ridx0_o, 0);
    check("rst_ridx1", ssit_ridx1_o, 0);
    check("rst_widx0", ssit_widx0_o, 0);
    check("rst_widx1", ssit_widx1_o, 0);
    check("rst_wssid", ssit_wssid_o, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Directed vectors: write lands exactly 4 cycles after the push cycle.
    for (int i = 0; i < 8; i++) begin
      env_vld[vecs[i].ld] = vecs[i].v0; env_id[vecs[i].ld] = vecs[i].s0;
      env_vld[vecs[i].st] = vecs[i].v1; env_id[vecs[i].st] = vecs[i].s1;
      push_one(vecs[i].ld, vecs[i].st);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clock);
        if (k == 2) begin
          check($sformatf("vec%0d_ridx0", i), ssit_ridx0_o, vecs[i].ld);
          check($sformatf("vec%0d_ridx1", i), ssit_ridx1_o, vecs[i].st);
        end
        if (k == 3) check($sformatf("vec%0d_we_early", i), ssit_we_o, 0);
        if (k == 4) begin
          check($sformatf("vec%0d_we", i), ssit_we_o, vecs[i].we);
          if (vecs[i].we) begin
            check($sformatf("vec%0d_widx0", i), ssit_widx0_o, vecs[i].ld);
            check($sformatf("vec%0d_widx1", i), ssit_widx1_o, vecs[i].st);
            check($sformatf("vec%0d_wssid", i), ssit_wssid_o, vecs[i].ssid);
          end
        end
        if (k == 5) begin
          check($sformatf("vec%0d_idle_busy", i), busy_o, 0);
          check($sformatf("vec%0d_idle_state", i), dbg_state_o, 0);
        end
      end
    end

    // Backpressure: five back-to-back reports into a 4-deep queue.
    do_reset();
    model_sync();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) push_one(12'h100 + 12'(i), 12'h300 + 12'(i));
    @(negedge clock);
    check("bp_rdy_low_when_full", viol_rdy_o, 0);
    check("bp_busy", busy_o, 1);
    wait_drain();
    check("bp_write_count", wr_cyc.size(), 5);
    for (int i = 1; i < wr_cyc.size(); i++) begin
      d = wr_cyc[i] - wr_cyc[i-1];
      check($sformatf("bp_spacing%0d", i), d, 4);
    end
    mon_en = 1'b0;

    // Reset asserted while the first of three queued reports is in RESP.
    for (int i = 0; i < 3; i++) push_one(12'h400 + 12'(i), 12'h500 + 12'(i));
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_we", ssit_we_o, 0);
    check("rstmid_clr", ssit_clr_o, 0);
    check("rstmid_flush", lfst_flush_o, 0);
    check("rstmid_busy", busy_o, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rstmid_rdy_after", viol_rdy_o, 1);
    check("rstmid_busy_after", busy_o, 0);
    d = we_count;
    repeat (10) @(negedge clock);
    check("rstmid_no_stale_write", we_count - d, 0);

    // Randomized reports over a small, pre-populated index range.
    for (int i = 0; i < 16; i++) begin
      env_vld[i] = 1'($urandom_range(0, 1));
      env_id[i]  = 7'($urandom_range(0, 3));
    end
    model_sync();
    mon_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      push_one(12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)));
    end
    wait_drain();
    mon_en = 1'b0;
    check("main_no_clear", clr_count, 0);

    // Cyclic clear on the short-period instance.
`ifdef SSIT_CYCLIC_CLEAR_EN
    c_mon_en = 1'b1;
    @(negedge clock);
    c_vld = 1'b1;
    repeat (150) @(negedge clock);
    c_vld = 1'b0;
    d = 0;
    while (c_busy && d < 50) begin
      @(negedge clock);
      d++;
    end
    repeat (20) @(negedge clock);
    c_mon_en = 1'b0;
    check("c_clear_count_in_range", 32'(c_clr_n >= 8 && c_clr_n <= 12), 1);
    check("c_writes_seen", 32'(c_we_n >= 20), 1);
`else
    repeat (40) @(negedge clock);
    check("c_no_clear_without_feature", c_clr_tot, 0);
`endif
    check("c_final_busy", c_busy, 0);
    check("c_final_rdy", c_rdy, 1);
    check("c_final_state", c_dbg, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
